counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/counter_seq_ctrl_if.sv | 39 +++
 rtl/counter_core.sv | 34 +++
 rtl/counter_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer.
//   state_t   - controller state encoding, also visible on the debug port
//   MODE_*    - run mode encodings on the 2-bit mode input
//   is_busy() - true for the states where a run is in progress
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_DWELL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_UP1 = 2'b00;  // count lo -> hi once
  localparam logic [1:0] MODE_DN1 = 2'b01;  // count hi -> lo once
  localparam logic [1:0] MODE_PP  = 2'b10;  // bounce between limits; 2'b11 behaves the same

  function automatic logic is_busy(input state_t s);
    return (s == S_UP) || (s == S_DOWN) || (s == S_DWELL);
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between a requester and counter_seq_ctrl.
//   master: drives start, stop, mode, lo_lim, hi_lim; observes status
//   slave : the sequencer; drives count, up_down, busy, done, turn, err,
//           dbg_state
//
// Handshake: start is a level sampled on every rising edge while the
// sequencer is idle; one cycle high is enough to launch a run, and a start
// seen while busy is dropped, not queued. stop is sampled on every rising
// edge while busy and wins over start when both are high in idle. done,
// turn and err are single-cycle pulses with no acknowledge.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  import counter_ctrl_pkg::*;

  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo_lim;
  logic [WIDTH-1:0] hi_lim;
  logic [WIDTH-1:0] count;
  logic             up_down;
  logic             busy;
  logic             done;
  logic             turn;
  logic             err;
  state_t           dbg_state;

  modport master (
    output start, stop, mode, lo_lim, hi_lim,
    input  count, up_down, busy, done, turn, err, dbg_state
  );

  modport slave (
    input  start, stop, mode, lo_lim, hi_lim,
    output count, up_down, busy, done, turn, err, dbg_state
  );

endinterface

// File: rtl/counter_core.sv
// Plain WIDTH-bit up/down counter datapath.
//   clk, reset - clock, asynchronous active-high reset (count -> 0)
//   load       - load load_val (highest priority after reset)
//   load_val   - value to load
//   en         - step by one in the direction given by up_down
//   up_down    - 1 increments, 0 decrements
//   count      - current value
// The counter wraps naturally; keeping it inside limits is the
// controller's job (it never enables a step past a limit).
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up_down ? (count + ONE) : (count - ONE);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Limit-bounded counter sequencer: one-shot up, one-shot down, or
// ping-pong between latched lo/hi limits with an optional hold (DWELL
// cycles) at each turnaround.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - counter_seq_ctrl_if slave: start/stop/mode/limits in,
//                count/up_down/busy/done/turn/err/dbg_state out
// Parameters: WIDTH (count width), DWELL (0..15 hold cycles at a turn).
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 0
) (
  input  logic              clk,
  input  logic              reset,
  counter_seq_ctrl_if.slave bus
);

  // Dwell counter runs 0 .. DWELL-1; only used when DWELL > 0.
  localparam bit         HAS_DWELL  = (DWELL > 0);
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t           state, state_next;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             dir, dir_next;
  logic [3:0]       dwell_cnt, dwell_next;
  logic             err_q, err_next;
  logic             latch;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             turn_c;
  logic             ping_pong;
  logic [WIDTH-1:0] count;

  assign ping_pong = mode_q[1];

  // Start loads from the live inputs (the latched copies update on the
  // same edge), so the first count is visible one cycle after start.
  assign load_val = (bus.mode == MODE_DN1) ? bus.hi_lim : bus.lo_lim;

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up_down  (state == S_UP),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= MODE_UP1;
      lo_q      <= '0;
      hi_q      <= '0;
      dir       <= 1'b1;
      dwell_cnt <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      dir       <= dir_next;
      dwell_cnt <= dwell_next;
      err_q     <= err_next;
      if (latch) begin
        mode_q <= bus.mode;
        lo_q   <= bus.lo_lim;
        hi_q   <= bus.hi_lim;
      end
    end
  end

  always_comb begin
    state_next = state;
    dir_next   = dir;
    dwell_next = dwell_cnt;
    err_next   = 1'b0;
    latch      = 1'b0;
    load       = 1'b0;
    en         = 1'b0;
    turn_c     = 1'b0;

    case (state)
      S_IDLE: begin
        // stop masks start here so a simultaneous pair does nothing.
        if (bus.start && !bus.stop) begin
          if (bus.lo_lim > bus.hi_lim) begin
            err_next = 1'b1;
          end else begin
            latch = 1'b1;
            load  = 1'b1;
            if (bus.mode == MODE_DN1) begin
              state_next = S_DOWN;
              dir_next   = 1'b0;
            end else begin
              state_next = S_UP;
              dir_next   = 1'b1;
            end
          end
        end
      end

      S_UP: begin
        if (bus.stop) begin
          state_next = S_IDLE;
        end else if (count != hi_q) begin
          en = 1'b1;
        end else if (!ping_pong) begin
          state_next = S_DONE;
        end else begin
          turn_c   = 1'b1;
          dir_next = 1'b0;
          if (HAS_DWELL) begin
            state_next = S_DWELL;
            dwell_next = 4'd0;
          end else begin
            state_next = S_DOWN;
          end
        end
      end

      S_DOWN: begin
        if (bus.stop) begin
          state_next = S_IDLE;
        end else if (count != lo_q) begin
          en = 1'b1;
        end else if (!ping_pong) begin
          state_next = S_DONE;
        end else begin
          turn_c   = 1'b1;
          dir_next = 1'b1;
          if (HAS_DWELL) begin
            state_next = S_DWELL;
            dwell_next = 4'd0;
          end else begin
            state_next = S_UP;
          end
        end
      end

      S_DWELL: begin
        // dir was already flipped on entry, so it names the next leg.
        if (bus.stop) begin
          state_next = S_IDLE;
        end else if (dwell_cnt == DWELL_LAST) begin
          state_next = dir ? S_UP : S_DOWN;
        end else begin
          dwell_next = dwell_cnt + 4'd1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.count     = count;
  assign bus.up_down   = dir;
  assign bus.busy      = is_busy(state);
  assign bus.done      = (state == S_DONE);
  assign bus.turn      = turn_c;
  assign bus.err       = err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;
  import counter_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // bus drives the DWELL=2 instance; bus0 mirrors the same stimulus into
  // a DWELL=0 instance.
  counter_seq_ctrl_if #(.WIDTH(4)) bus ();
  counter_seq_ctrl_if #(.WIDTH(4)) bus0 ();

  assign bus0.start  = bus.start;
  assign bus0.stop   = bus.stop;
  assign bus0.mode   = bus.mode;
  assign bus0.lo_lim = bus.lo_lim;
  assign bus0.hi_lim = bus.hi_lim;

  counter_seq_ctrl #(.WIDTH(4), .DWELL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  counter_seq_ctrl #(.WIDTH(4), .DWELL(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sel=0 -> DWELL=2 instance, sel=1 -> DWELL=0 instance
  task automatic chk_out(input string tag, input bit sel, input logic [3:0] c,
                         input logic ud, input logic b, input logic d,
                         input logic t, input logic e);
    logic [3:0] ac;
    logic au, ab, ad, at, ae;
    if (sel) begin
      ac = bus0.count; au = bus0.up_down; ab = bus0.busy;
      ad = bus0.done;  at = bus0.turn;    ae = bus0.err;
    end else begin
      ac = bus.count;  au = bus.up_down;  ab = bus.busy;
      ad = bus.done;   at = bus.turn;     ae = bus.err;
    end
    chk($sformatf("%s/d%0d count", tag, sel), 8'(ac), 8'(c));
    chk($sformatf("%s/d%0d up_down", tag, sel), 8'(au), 8'(ud));
    chk($sformatf("%s/d%0d busy", tag, sel), 8'(ab), 8'(b));
    chk($sformatf("%s/d%0d done", tag, sel), 8'(ad), 8'(d));
    chk($sformatf("%s/d%0d turn", tag, sel), 8'(at), 8'(t));
    chk($sformatf("%s/d%0d err", tag, sel), 8'(ae), 8'(e));
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1 time unit
  // after the following rising edge with the inputs still applied.
  task automatic drive(input logic s, input logic p, input logic [1:0] m,
                       input logic [3:0] lo, input logic [3:0] hi);
    @(negedge clk);
    bus.start  = s;
    bus.stop   = p;
    bus.mode   = m;
    bus.lo_lim = lo;
    bus.hi_lim = hi;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] e_count;
    logic       e_ud;
    logic       e_busy;
    logic       e_done;
    logic       e_turn;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic p, input logic [1:0] m,
                     input logic [3:0] lo, input logic [3:0] hi,
                     input logic [3:0] c, input logic ud, input logic b,
                     input logic d, input logic t, input logic e);
    vec_t v;
    v.start = s; v.stop = p; v.mode = m; v.lo = lo; v.hi = hi;
    v.e_count = c; v.e_ud = ud; v.e_busy = b; v.e_done = d;
    v.e_turn = t; v.e_err = e;
    vecs.push_back(v);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 2'b00;
    bus.lo_lim = 4'd0;
    bus.hi_lim = 4'd0;

    // one-shot up 3..7
    add(1, 0, 2'b00, 4'd3, 4'd7, 4'd3, 1, 1, 0, 0, 0);
    for (int c = 4; c <= 7; c++) add(0, 0, 2'b00, 4'd0, 4'd0, 4'(c), 1, 1, 0, 0, 0);
    add(0, 0, 2'b00, 4'd0, 4'd0, 4'd7, 1, 0, 1, 0, 0);
    add(0, 0, 2'b00, 4'd0, 4'd0, 4'd7, 1, 0, 0, 0, 0);
    // one-shot down 9..2
    add(1, 0, 2'b01, 4'd2, 4'd9, 4'd9, 0, 1, 0, 0, 0);
    for (int c = 8; c >= 2; c--) add(0, 0, 2'b01, 4'd0, 4'd0, 4'(c), 0, 1, 0, 0, 0);
    add(0, 0, 2'b01, 4'd0, 4'd0, 4'd2, 0, 0, 1, 0, 0);
    add(0, 0, 2'b01, 4'd0, 4'd0, 4'd2, 0, 0, 0, 0, 0);
    // rejected start lo>hi
    add(1, 0, 2'b00, 4'd8, 4'd4, 4'd2, 0, 0, 0, 0, 1);
    add(0, 0, 2'b00, 4'd8, 4'd4, 4'd2, 0, 0, 0, 0, 0);
    // start+stop together in idle
    add(1, 1, 2'b00, 4'd1, 4'd3, 4'd2, 0, 0, 0, 0, 0);
    add(0, 0, 2'b00, 4'd1, 4'd3, 4'd2, 0, 0, 0, 0, 0);

    // reset state
    #1 reset = 1'b1;
    #3;
    chk_out("reset", 0, 4'd0, 1, 0, 0, 0, 0);
    chk_out("reset", 1, 4'd0, 1, 0, 0, 0, 0);
    chk("reset state", 8'(dut.bus.dbg_state), 8'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // table: one-shot behaviour is identical for both instances
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].lo, vecs[i].hi);
      for (int s = 0; s < 2; s++)
        chk_out($sformatf("vec%0d", i), s[0], vecs[i].e_count, vecs[i].e_ud,
                vecs[i].e_busy, vecs[i].e_done, vecs[i].e_turn, vecs[i].e_err);
    end

    // ping-pong 0..15 with DWELL=2 (DWELL=2 instance only)
    drive(1, 0, 2'b10, 4'd0, 4'd15);
    chk_out("pp0", 0, 4'd0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      drive(0, 0, 2'b10, 4'd0, 4'd15);
      chk_out($sformatf("pp_up%0d", i), 0, 4'(i), 1, 1, 0, (i == 15), 0);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 2'b10, 4'd0, 4'd15);
      chk_out($sformatf("pp_dwell_hi%0d", k), 0, 4'd15, 0, 1, 0, 0, 0);
      chk($sformatf("pp_dwell_hi%0d state", k), 8'(bus.dbg_state), 8'(S_DWELL));
    end
    drive(0, 0, 2'b10, 4'd0, 4'd15);
    chk_out("pp_down15", 0, 4'd15, 0, 1, 0, 0, 0);
    for (int i = 14; i >= 0; i--) begin
      drive(0, 0, 2'b10, 4'd0, 4'd15);
      chk_out($sformatf("pp_dn%0d", i), 0, 4'(i), 0, 1, 0, (i == 0), 0);
    end
    drive(0, 0, 2'b10, 4'd0, 4'd15);
    chk_out("pp_dwell_lo", 0, 4'd0, 1, 1, 0, 0, 0);
    drive(0, 1, 2'b10, 4'd0, 4'd15);
    chk_out("pp_stop_dwell", 0, 4'd0, 1, 0, 0, 0, 0);
    chk("pp_stop_dwell d1 busy", 8'(bus0.busy), 8'd0);

    // lo==hi one-shot: done two cycles after start
    drive(1, 0, 2'b00, 4'd5, 4'd5);
    chk_out("eq_os1", 0, 4'd5, 1, 1, 0, 0, 0);
    chk_out("eq_os1", 1, 4'd5, 1, 1, 0, 0, 0);
    drive(0, 0, 2'b00, 4'd5, 4'd5);
    chk_out("eq_os2", 0, 4'd5, 1, 0, 1, 0, 0);
    chk_out("eq_os2", 1, 4'd5, 1, 0, 1, 0, 0);
    drive(0, 0, 2'b00, 4'd5, 4'd5);
    chk_out("eq_os3", 1, 4'd5, 1, 0, 0, 0, 0);

    // lo==hi ping-pong (mode 11), DWELL=0: turn every cycle
    drive(1, 0, 2'b11, 4'd6, 4'd6);
    chk_out("eq_pp1", 1, 4'd6, 1, 1, 0, 1, 0);
    drive(0, 0, 2'b11, 4'd6, 4'd6);
    chk_out("eq_pp2", 1, 4'd6, 0, 1, 0, 1, 0);
    drive(0, 0, 2'b11, 4'd6, 4'd6);
    chk_out("eq_pp3", 1, 4'd6, 1, 1, 0, 1, 0);
    drive(0, 1, 2'b11, 4'd6, 4'd6);
    chk_out("eq_pp_stop", 1, 4'd6, 1, 0, 0, 0, 0);
    chk("eq_pp_stop d0 busy", 8'(bus.busy), 8'd0);

    // stop at count 5 in ping-pong; start while busy ignored
    drive(1, 0, 2'b10, 4'd2, 4'd12);
    chk_out("stp2", 0, 4'd2, 1, 1, 0, 0, 0);
    drive(0, 0, 2'b10, 4'd2, 4'd12);
    chk_out("stp3", 0, 4'd3, 1, 1, 0, 0, 0);
    drive(1, 0, 2'b00, 4'd9, 4'd10);
    chk_out("stp_busy_start", 0, 4'd4, 1, 1, 0, 0, 0);
    drive(0, 0, 2'b10, 4'd2, 4'd12);
    chk_out("stp5", 0, 4'd5, 1, 1, 0, 0, 0);
    drive(0, 1, 2'b10, 4'd2, 4'd12);
    chk_out("stp_idle", 0, 4'd5, 1, 0, 0, 0, 0);
    chk_out("stp_idle", 1, 4'd5, 1, 0, 0, 0, 0);
    drive(0, 0, 2'b10, 4'd2, 4'd12);
    chk_out("stp_hold", 0, 4'd5, 1, 0, 0, 0, 0);
    drive(1, 1, 2'b00, 4'd1, 4'd3);
    chk_out("stp_startstop", 0, 4'd5, 1, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 4'd1, 4'd3);
    chk_out("stp_after", 0, 4'd5, 1, 0, 0, 0, 0);

    // asynchronous reset mid-run at count 11
    drive(1, 0, 2'b00, 4'd4, 4'd14);
    chk_out("ar4", 0, 4'd4, 1, 1, 0, 0, 0);
    for (int i = 5; i <= 11; i++) begin
      drive(0, 0, 2'b00, 4'd4, 4'd14);
      chk($sformatf("ar%0d count", i), 8'(bus.count), 8'(i));
    end
    #2 reset = 1'b1;
    #1;
    chk_out("ar_async", 0, 4'd0, 1, 0, 0, 0, 0);
    chk_out("ar_async", 1, 4'd0, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 2'b00, 4'd4, 4'd14);
    chk_out("ar_released", 0, 4'd0, 1, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 4'd4, 4'd14);
    chk_out("ar_quiet", 1, 4'd0, 1, 0, 0, 0, 0);
    drive(1, 0, 2'b00, 4'd1, 4'd2);
    chk_out("ar_first_start", 0, 4'd1, 1, 1, 0, 0, 0);
    drive(0, 0, 2'b00, 4'd1, 4'd2);
    chk_out("ar_step", 0, 4'd2, 1, 1, 0, 0, 0);
    drive(0, 0, 2'b00, 4'd1, 4'd2);
    chk_out("ar_done", 0, 4'd2, 1, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
